// File: rtl/toggle_request_conditioner.sv
// rtl/toggle_request_conditioner.sv - synchronize, debounce and pulse-shape a raw toggle request
//
// Purpose: turns a raw, asynchronous, possibly bouncing toggle request into a
// clean one-cycle pulse for a T flip-flop on the same clock, and keeps a
// wrapping count of the pulses issued.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   btn_in       raw asynchronous request (may bounce)
//   en           gates t pulse generation; debouncing runs regardless
//   t            one-cycle toggle pulse, issued on an accepted 0->1 change
//   btn_stable   debounced request level
//   busy         high while a level change is being qualified
//   press_count  number of t pulses issued, wraps on overflow
module toggle_request_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_in,
  input  logic             en,
  output logic             t,
  output logic             btn_stable,
  output logic             busy,
  output logic [CNT_W-1:0] press_count
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_t;
  logic                   r_stable;
  logic                   r_busy;
  logic [CNT_W-1:0]       r_press_count;

  logic                   w_btn_sync;
  state_t                 w_state_nxt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   w_t_nxt;
  logic                   w_stable_nxt;
  logic                   w_busy_nxt;

  // Only the first synchronizer flop samples btn_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign w_btn_sync = r_sync[SYNC_STAGES-1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; cnt counts consecutive cycles at the candidate level,
  // starting at 1 on the cycle the change is first seen.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE_LOW: begin
        if (w_btn_sync) begin
          w_state_nxt = CHK_HIGH;
          w_cnt_nxt   = CW'(1);
        end
      end
      CHK_HIGH: begin
        if (!w_btn_sync) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      IDLE_HIGH: begin
        if (!w_btn_sync) begin
          w_state_nxt = CHK_LOW;
          w_cnt_nxt   = CW'(1);
        end
      end
      CHK_LOW: begin
        if (w_btn_sync) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic; outputs are registered from the next state so they change
  // on the same edge as the state they describe.
  always_comb begin
    w_stable_nxt = (w_state_nxt == IDLE_HIGH) || (w_state_nxt == CHK_LOW);
    w_busy_nxt   = (w_state_nxt == CHK_HIGH)  || (w_state_nxt == CHK_LOW);
    // Only a rising acceptance can pulse; release acceptance never does.
    w_t_nxt      = en && (r_state == CHK_HIGH) && (w_state_nxt == IDLE_HIGH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t           <= 1'b0;
      r_stable      <= 1'b0;
      r_busy        <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_t      <= w_t_nxt;
      r_stable <= w_stable_nxt;
      r_busy   <= w_busy_nxt;
      if (w_t_nxt) begin
        r_press_count <= r_press_count + CNT_W'(1);
      end
    end
  end

  assign t           = r_t;
  assign btn_stable  = r_stable;
  assign busy        = r_busy;
  assign press_count = r_press_count;

endmodule

// File: tb/tb_toggle_request_conditioner.sv
// tb/tb_toggle_request_conditioner.sv - directed scoreboard bench for toggle_request_conditioner
module tb_toggle_request_conditioner;

  logic       clk;
  logic       rst_n;
  logic       btn_in;
  logic       en;
  logic       t;
  logic       btn_stable;
  logic       busy;
  logic [1:0] press_count;
  logic       q;

  int n_checks;
  int n_errors;
  logic [1:0] exp_cnt;

  typedef struct {
    string      tag;
    logic       t;
    logic       st;
    logic       busy;
    logic [1:0] cnt;
  } exp_s;

  exp_s sbq[$];

  toggle_request_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .en         (en),
    .t          (t),
    .btn_stable (btn_stable),
    .busy       (busy),
    .press_count(press_count)
  );

  // Downstream T flip-flop driven by the conditioned pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else if (t) q <= ~q;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_s e;
    if (sbq.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sbq.pop_front();
      chk({e.tag, ".t"},      8'(t),           8'(e.t));
      chk({e.tag, ".stable"}, 8'(btn_stable),  8'(e.st));
      chk({e.tag, ".busy"},   8'(busy),        8'(e.busy));
      chk({e.tag, ".count"},  8'(press_count), 8'(e.cnt));
    end
  endtask

  // Push expectation for the coming edge, advance one clock, compare just after it.
  task automatic tick(input string tag, input logic et, input logic est,
                      input logic eb, input logic [1:0] ec);
    sbq.push_back('{tag, et, est, eb, ec});
    @(posedge clk);
    #1;
    pop_check();
  endtask

  // Drive a steady level and follow the full qualification timeline:
  // two synchronizer edges, three busy edges, acceptance on edge 6, then one idle edge.
  task automatic settle(input string tag, input logic lvl, input logic en_v);
    logic pulse;
    btn_in = lvl;
    en     = en_v;
    for (int e = 1; e <= 6; e++) begin
      pulse = lvl && en_v && (e == 6);
      if (pulse) exp_cnt = exp_cnt + 2'd1;
      tick(tag, pulse, (e == 6) ? lvl : ~lvl, (e >= 3) && (e <= 5), exp_cnt);
    end
    tick(tag, 1'b0, lvl, 1'b0, exp_cnt);
  endtask

  initial begin
    logic [9:0] bounce_btn;
    logic [9:0] bounce_busy;
    n_checks = 0;
    n_errors = 0;
    exp_cnt  = 2'd0;
    rst_n    = 1'b0;
    btn_in   = 1'b0;
    en       = 1'b1;

    #12;
    sbq.push_back('{"reset", 1'b0, 1'b0, 1'b0, 2'd0});
    pop_check();
    chk("reset.q", 8'(q), 8'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick("idle", 1'b0, 1'b0, 1'b0, 2'd0);
    tick("idle", 1'b0, 1'b0, 1'b0, 2'd0);

    settle("press1", 1'b1, 1'b1);
    settle("release1", 1'b0, 1'b1);

    // btn_sync high for 3 cycles, low for 1, then held high.
    bounce_btn  = 10'b1111110111;
    bounce_busy = 10'b0111011100;
    for (int e = 1; e <= 10; e++) begin
      btn_in = bounce_btn[e-1];
      if (e == 10) exp_cnt = exp_cnt + 2'd1;
      tick("bounce", e == 10, e == 10, bounce_busy[e-1], exp_cnt);
    end
    tick("bounce_after", 1'b0, 1'b1, 1'b0, exp_cnt);
    settle("release2", 1'b0, 1'b1);

    settle("en_low_press", 1'b1, 1'b0);
    en = 1'b1;
    for (int i = 0; i < 3; i++) tick("en_raised", 1'b0, 1'b1, 1'b0, exp_cnt);
    settle("release3", 1'b0, 1'b1);

    settle("press3", 1'b1, 1'b1);
    settle("release4", 1'b0, 1'b1);
    settle("press_wrap", 1'b1, 1'b1);
    chk("wrap.count", 8'(press_count), 8'd0);
    settle("release5", 1'b0, 1'b1);
    settle("press5", 1'b1, 1'b1);
    chk("tff.q_after_5", 8'(q), 8'd1);
    settle("release6", 1'b0, 1'b1);

    // Reset in CHK_HIGH with cnt at 2, between edges.
    btn_in = 1'b1;
    tick("pre_rst", 1'b0, 1'b0, 1'b0, exp_cnt);
    tick("pre_rst", 1'b0, 1'b0, 1'b0, exp_cnt);
    tick("pre_rst", 1'b0, 1'b0, 1'b1, exp_cnt);
    tick("pre_rst", 1'b0, 1'b0, 1'b1, exp_cnt);
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 2'd0;
    sbq.push_back('{"mid_rst", 1'b0, 1'b0, 1'b0, 2'd0});
    pop_check();
    chk("mid_rst.q", 8'(q), 8'd0);
    #3;
    rst_n = 1'b1;
    settle("rst_repress", 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
